// File: rtl/ring_mon_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : ring_mon_pkg
//  Purpose : Shared types and constants for the ring phase monitor.
//            - RING_W      : width of the one-hot phase vector (8)
//            - IDX_W       : width of the binary phase index (3)
//            - mon_state_e : monitor state encoding (SEEK, TRACK, FAULT)
//  Revision: 1.0  initial release
// ============================================================================
package ring_mon_pkg;

  localparam int RING_W = 8;
  localparam int IDX_W  = 3;

  typedef enum logic [1:0] {
    SEEK  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } mon_state_e;

endpackage : ring_mon_pkg
`default_nettype wire

// File: rtl/onehot_enc8.sv
`default_nettype none
// ============================================================================
//  Module  : onehot_enc8
//  Purpose : Combinational 8-bit one-hot to binary encoder with legality flag.
//  Ports   :
//    vec_i    in  [RING_W-1:0]  phase vector
//    idx_o    out [IDX_W-1:0]   binary index (meaningful only when onehot_o)
//    onehot_o out 1             exactly one bit of vec_i is set
//  Revision: 1.0  initial release
// ============================================================================
module onehot_enc8
  import ring_mon_pkg::*;
(
  input  logic [RING_W-1:0] vec_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              onehot_o
);

  // OR-reduction encoder: exact for one-hot inputs; the result for illegal
  // inputs is never consumed because onehot_o gates every use.
  always_comb begin
    idx_o = '0;
    for (int k = 0; k < RING_W; k++) begin
      if (vec_i[k]) begin
        idx_o = idx_o | k[IDX_W-1:0];
      end
    end
  end

  // Non-zero and clearing the lowest set bit leaves nothing behind.
  assign onehot_o = (vec_i != '0) && ((vec_i & (vec_i - 1'b1)) == '0);

endmodule : onehot_enc8
`default_nettype wire

// File: rtl/ring_phase_monitor.sv
`default_nettype none
// ============================================================================
//  Module  : ring_phase_monitor
//  Purpose : Checks the one-hot phase vector of a ring counter every cycle,
//            converts it to a binary index, counts revolutions and flags
//            illegal or out-of-order phases.
//  Params  : REV_W (revolution counter width), DIR (0 = index increments,
//            1 = index decrements)
//  Ports   :
//    clk        in   1       rising-edge clock
//    rst        in   1       synchronous active-high reset
//    T          in   8       one-hot phase vector
//    idx        out  3       index of last accepted phase
//    valid      out  1       monitor locked, idx meaningful
//    rev_cnt    out  REV_W   completed revolutions (wraps)
//    rev_pulse  out  1       one-cycle pulse per revolution
//    err        out  1       one-cycle pulse per detected fault
//    fault      out  1       sticky fault flag
//    err_cnt    out  8       saturating fault count (RING_MON_ERRCNT_EN only)
//  Macro   : RING_MON_ERRCNT_EN enables the err_cnt port and register.
//  Revision: 1.0  initial release
// ============================================================================
module ring_phase_monitor
  import ring_mon_pkg::*;
#(
  parameter int REV_W = 8,
  parameter bit DIR   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RING_W-1:0] T,
  output logic [IDX_W-1:0]  idx,
  output logic              valid,
  output logic [REV_W-1:0]  rev_cnt,
  output logic              rev_pulse,
  output logic              err,
`ifdef RING_MON_ERRCNT_EN
  output logic [7:0]        err_cnt,
`endif
  output logic              fault
);

  mon_state_e         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               valid_q, valid_d;
  logic [REV_W-1:0]   rev_cnt_q, rev_cnt_d;
  logic               rev_pulse_q, rev_pulse_d;
  logic               err_q, err_d;
  logic               fault_q, fault_d;

  logic [IDX_W-1:0]   enc_idx;
  logic               is_onehot;
  logic [IDX_W-1:0]   exp_idx;
  logic               hold_ok;
  logic               step_ok;
  logic               wrap_step;

  onehot_enc8 u_enc (
    .vec_i    (T),
    .idx_o    (enc_idx),
    .onehot_o (is_onehot)
  );

  assign exp_idx   = DIR ? (idx_q - 3'd1) : (idx_q + 3'd1);
  assign hold_ok   = is_onehot && (enc_idx == idx_q);
  assign step_ok   = is_onehot && (enc_idx == exp_idx);
  // A revolution completes when the accepted step leaves the last phase.
  assign wrap_step = (idx_q == (DIR ? 3'd0 : 3'd7));

  // State register and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEEK;
      idx_q       <= '0;
      valid_q     <= 1'b0;
      rev_cnt_q   <= '0;
      rev_pulse_q <= 1'b0;
      err_q       <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      valid_q     <= valid_d;
      rev_cnt_q   <= rev_cnt_d;
      rev_pulse_q <= rev_pulse_d;
      err_q       <= err_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEEK:    if (is_onehot) state_d = TRACK;
      TRACK:   if (!(hold_ok || step_ok)) state_d = FAULT;
      FAULT:   if (is_onehot) state_d = TRACK;
      default: state_d = SEEK;
    endcase
  end

  // Output next-value logic
  always_comb begin
    idx_d       = idx_q;
    rev_cnt_d   = rev_cnt_q;
    rev_pulse_d = 1'b0;
    err_d       = 1'b0;
    fault_d     = fault_q;
    valid_d     = (state_d == TRACK);
    case (state_q)
      SEEK, FAULT: begin
        // Relock never counts a revolution.
        if (is_onehot) idx_d = enc_idx;
      end
      TRACK: begin
        if (hold_ok) begin
          idx_d = idx_q;
        end else if (step_ok) begin
          idx_d = exp_idx;
          if (wrap_step) begin
            rev_cnt_d   = rev_cnt_q + 1'b1;
            rev_pulse_d = 1'b1;
          end
        end else begin
          err_d   = 1'b1;
          fault_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign idx       = idx_q;
  assign valid     = valid_q;
  assign rev_cnt   = rev_cnt_q;
  assign rev_pulse = rev_pulse_q;
  assign err       = err_q;
  assign fault     = fault_q;

`ifdef RING_MON_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Counts alongside the err pulse it accompanies; holds at all-ones.
  assign err_cnt_d = (err_d && (err_cnt_q != 8'hFF)) ? (err_cnt_q + 8'd1) : err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'h00;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule : ring_phase_monitor
`default_nettype wire

// File: tb/tb_ring_phase_monitor.sv
`default_nettype none
// ============================================================================
//  Module  : tb_ring_phase_monitor
//  Purpose : Self-checking bench for ring_phase_monitor (REV_W=8, DIR=0).
//            Table of {rst, T, expected outputs} vectors plus hand-written
//            sequences for revolution-counter wrap and err_cnt saturation
//            (the latter only when RING_MON_ERRCNT_EN is defined).
//  Revision: 1.0  initial release
// ============================================================================
module tb_ring_phase_monitor;

  typedef struct {
    logic       rst;
    logic [7:0] t;
    logic [2:0] idx;
    logic       valid;
    logic [7:0] rc;
    logic       rp;
    logic       err;
    logic       fault;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] T;
  logic [2:0] idx;
  logic       valid;
  logic [7:0] rev_cnt;
  logic       rev_pulse;
  logic       err;
  logic       fault;
`ifdef RING_MON_ERRCNT_EN
  logic [7:0] err_cnt;
`endif

  int   pass_cnt  = 0;
  int   total_cnt = 0;
  vec_t vecs[$];

  ring_phase_monitor #(.REV_W(8), .DIR(1'b0)) dut (
    .clk       (clk),
    .rst       (rst),
    .T         (T),
    .idx       (idx),
    .valid     (valid),
    .rev_cnt   (rev_cnt),
    .rev_pulse (rev_pulse),
    .err       (err),
`ifdef RING_MON_ERRCNT_EN
    .err_cnt   (err_cnt),
`endif
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [7:0] t, input logic [2:0] i,
                     input logic v, input logic [7:0] rc, input logic rp,
                     input logic e, input logic f);
    vec_t x;
    x.rst = r; x.t = t; x.idx = i; x.valid = v;
    x.rc = rc; x.rp = rp; x.err = e; x.fault = f;
    vecs.push_back(x);
  endtask

  // Drive at the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic r, input logic [7:0] t);
    @(negedge clk);
    rst = r;
    T   = t;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    rst = 1'b1;
    T   = 8'h00;

    //   rst  T      idx v  rc     rp e  f
    add(1, 8'h00, 0, 0, 8'd0, 0, 0, 0);
    add(1, 8'h01, 0, 0, 8'd0, 0, 0, 0);
    add(0, 8'h01, 0, 1, 8'd0, 0, 0, 0);   // lock in SEEK
    add(0, 8'h02, 1, 1, 8'd0, 0, 0, 0);
    add(0, 8'h04, 2, 1, 8'd0, 0, 0, 0);
    add(0, 8'h08, 3, 1, 8'd0, 0, 0, 0);
    add(0, 8'h10, 4, 1, 8'd0, 0, 0, 0);
    add(0, 8'h20, 5, 1, 8'd0, 0, 0, 0);
    add(0, 8'h40, 6, 1, 8'd0, 0, 0, 0);
    add(0, 8'h80, 7, 1, 8'd0, 0, 0, 0);
    add(0, 8'h01, 0, 1, 8'd1, 1, 0, 0);   // first revolution
    add(0, 8'h02, 1, 1, 8'd1, 0, 0, 0);
    add(0, 8'h04, 2, 1, 8'd1, 0, 0, 0);
    add(0, 8'h08, 3, 1, 8'd1, 0, 0, 0);
    add(0, 8'h10, 4, 1, 8'd1, 0, 0, 0);
    add(0, 8'h20, 5, 1, 8'd1, 0, 0, 0);
    add(0, 8'h40, 6, 1, 8'd1, 0, 0, 0);
    add(0, 8'h80, 7, 1, 8'd1, 0, 0, 0);
    add(0, 8'h01, 0, 1, 8'd2, 1, 0, 0);   // second revolution
    add(0, 8'h02, 1, 1, 8'd2, 0, 0, 0);
    add(0, 8'h04, 2, 1, 8'd2, 0, 0, 0);
    add(0, 8'h10, 2, 0, 8'd2, 0, 1, 1);   // skipped phase 3
    add(0, 8'h20, 5, 1, 8'd2, 0, 0, 1);   // relock, fault sticky
    add(0, 8'h03, 5, 0, 8'd2, 0, 1, 1);   // multi-bit
    add(0, 8'h00, 5, 0, 8'd2, 0, 0, 1);   // no re-pulse in FAULT
    add(0, 8'h00, 5, 0, 8'd2, 0, 0, 1);
    add(0, 8'h00, 5, 0, 8'd2, 0, 0, 1);
    add(0, 8'h01, 0, 1, 8'd2, 0, 0, 1);   // relock at 0, no revolution
    add(0, 8'h02, 1, 1, 8'd2, 0, 0, 1);
    add(0, 8'h04, 2, 1, 8'd2, 0, 0, 1);
    add(0, 8'h08, 3, 1, 8'd2, 0, 0, 1);
    add(0, 8'h08, 3, 1, 8'd2, 0, 0, 1);   // stall is legal
    add(0, 8'h08, 3, 1, 8'd2, 0, 0, 1);
    add(0, 8'h08, 3, 1, 8'd2, 0, 0, 1);
    add(0, 8'h08, 3, 1, 8'd2, 0, 0, 1);
    add(0, 8'h04, 3, 0, 8'd2, 0, 1, 1);   // reversed step
    add(0, 8'h04, 2, 1, 8'd2, 0, 0, 1);
    add(1, 8'h08, 0, 0, 8'd0, 0, 0, 0);   // mid-run reset
    add(0, 8'h00, 0, 0, 8'd0, 0, 0, 0);   // SEEK, illegal, no err
    add(0, 8'h03, 0, 0, 8'd0, 0, 0, 0);
    add(0, 8'h80, 7, 1, 8'd0, 0, 0, 0);   // lock at 7
    add(0, 8'h01, 0, 1, 8'd1, 1, 0, 0);   // first step after lock wraps

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].t);
      check($sformatf("vec[%0d] idx,valid,rev_cnt,rev_pulse,err,fault", i),
            {18'd0, idx, valid, rev_cnt, rev_pulse, err, fault},
            {18'd0, vecs[i].idx, vecs[i].valid, vecs[i].rc, vecs[i].rp,
             vecs[i].err, vecs[i].fault});
    end

    // Revolution counter wrap: 256 full revolutions from a lock at phase 0.
    step(1'b1, 8'h00);
    step(1'b0, 8'h01);
    check("wrap_lock_valid", {31'd0, valid}, 32'd1);
    for (int r = 0; r < 256; r++) begin
      for (int b = 1; b < 8; b++) step(1'b0, 8'h01 << b);
      step(1'b0, 8'h01);
      if (r == 254) begin
        check("rev_cnt_allones", {24'd0, rev_cnt}, 32'hFF);
        check("rev_pulse_at_255", {31'd0, rev_pulse}, 32'd1);
      end
    end
    check("rev_cnt_wrap_zero", {24'd0, rev_cnt}, 32'd0);
    check("rev_pulse_on_wrap", {31'd0, rev_pulse}, 32'd1);
    check("no_fault_after_revs", {31'd0, fault}, 32'd0);

`ifdef RING_MON_ERRCNT_EN
    step(1'b1, 8'h00);
    check("err_cnt_reset", {24'd0, err_cnt}, 32'd0);
    for (int n = 1; n <= 300; n++) begin
      step(1'b0, 8'h01);   // lock (from SEEK or FAULT)
      step(1'b0, 8'h00);   // illegal in TRACK -> one err
      if (n == 100) check("err_cnt_100", {24'd0, err_cnt}, 32'd100);
      if (n == 255) check("err_cnt_255", {24'd0, err_cnt}, 32'hFF);
    end
    check("err_cnt_saturated", {24'd0, err_cnt}, 32'hFF);
    step(1'b1, 8'h00);
    check("err_cnt_cleared", {24'd0, err_cnt}, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_ring_phase_monitor
`default_nettype wire

// File: doc/ring_phase_monitor.md
# ring_phase_monitor

Consumes the 8-bit one-hot phase vector produced by the ring counter and checks it cycle by cycle. Outputs the binary phase index, counts completed revolutions, and flags illegal or out-of-order patterns. It sits directly downstream of the ring counter. It is the point where the one-hot phase becomes a binary index and a revolution count for the display and control logic.

## Interface
- REV_W, default 8: width of the revolution counter.
- DIR, default 0: expected rotation. 0 = bit k to bit k+1 (index increments); 1 = bit k to bit k-1 (index decrements).
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- T  input  8  one-hot phase vector from the ring counter, sampled every clk edge.
- idx  output  3  binary index of the last accepted phase.
- valid  output  1  high while the monitor is locked and idx is meaningful.
- rev_cnt  output  REV_W  completed revolutions, wraps modulo 2^REV_W.
- rev_pulse  output  1  one-cycle pulse on each completed revolution.
- err  output  1  one-cycle pulse on each detected fault.
- fault  output  1  sticky fault flag, cleared only by rst.
- err_cnt  output  8  saturating fault count; present only with RING_MON_ERRCNT_EN.

## Operation
- States: SEEK, TRACK, FAULT. Reset state is SEEK.
- One-hot test: exactly one bit of T set. The values 8'h00 and any multi-bit value are illegal.
- SEEK:
  - T one-hot: go to TRACK, idx <= enc(T), valid <= 1.
  - Otherwise: stay in SEEK, valid = 0.
  - No fault is raised in SEEK.
- TRACK, with exp = idx+1 mod 8 (DIR=0) or idx-1 mod 8 (DIR=1):
  - T one-hot and enc(T) == idx: hold. No change; stalls are legal.
  - T one-hot and enc(T) == exp: idx <= exp.
    - If DIR=0 and the step is 7 to 0, or DIR=1 and the step is 0 to 7: rev_cnt <= rev_cnt+1 and rev_pulse <= 1.
  - Anything else (illegal pattern, skipped phase, or reversed step): go to FAULT, err <= 1, fault <= 1, valid <= 0. idx holds its last value.
- FAULT:
  - T one-hot: go to TRACK with idx <= enc(T) and valid <= 1. No revolution is counted on this relock.
  - Otherwise: stay in FAULT.
  - err is not re-pulsed while in FAULT.
- rev_cnt is not cleared by a fault. Only rst clears it.

## Timing
- All outputs are registered. A T sample at edge n is reflected on the outputs after edge n, so latency is 1 cycle.
- Reset values: idx=0, valid=0, rev_cnt=0, rev_pulse=0, err=0, fault=0, err_cnt=0, state=SEEK.
- rst asserted mid-operation: at the next edge every output and the state return to their reset values, whatever T is. The first sample evaluated after rst deasserts is handled in SEEK.
- rev_pulse and err are high for exactly one cycle per event. They cannot both be high in the same cycle.
- rev_cnt wrap: all-ones + 1 gives 0, with rev_pulse still asserted.
- The first cycle after entering TRACK compares against the idx just loaded.

## Configuration
- Macro: RING_MON_ERRCNT_EN.
- Defined:
  - The err_cnt port exists.
  - err_cnt increments on each err pulse and saturates at 8'hFF.
  - rst clears it.
- Undefined:
  - The err_cnt port and its register are absent.
  - All other behaviour is identical.

## Structure
- Shared package ring_mon_pkg holds:
  - the state enum (SEEK, TRACK, FAULT);
  - the constant RING_W = 8;
  - the constant IDX_W = 3.
- Sub-module onehot_enc8 (combinational):
  - input: 8-bit vector;
  - outputs: 3-bit index and an is_onehot flag.
  - ring_phase_monitor instantiates it once on T.

## Test plan
- rst=1 for 2 cycles, then T=8'h01, 02, 04 with DIR=0 -> valid=1 from the first cycle after the 01 sample; idx=0, 1, 2 one cycle after each sample; err=0.
- Drive T through 01 to 80 and back to 01 twice -> rev_pulse high once per 80-to-01 step; rev_cnt=2.
- In TRACK at idx=2, drive T=8'h10 (skips 3) -> err=1 for one cycle, fault=1, valid=0, idx stays 2. Then T=8'h20 -> TRACK, idx=5, fault still 1.
- T=8'h03 in TRACK -> FAULT. Then T=8'h00 for 3 cycles -> remain in FAULT, valid=0, only one err pulse. Then T=8'h01 -> valid=1, idx=0.
- Hold T=8'h08 for 5 cycles in TRACK -> idx=3 steady, no err. Assert rst mid-run -> all outputs 0 at the next edge.
- With RING_MON_ERRCNT_EN defined, inject 300 faults -> err_cnt=8'hFF (saturated).
